// File: rtl/fifo_burst_checker.sv
// Read-side burst checker for the loopback FIFO: waits for a full burst, drains it,
// checks the incrementing pattern. Optional first-mismatch capture: FIFO_BURST_CHECKER_ERR_CAPTURE_EN.
module fifo_burst_checker #(
  parameter int BURST_LEN    = 256,
  parameter int CNT_W        = 9,
  parameter int WAIT_TIMEOUT = 5000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [7:0]       expect_seed,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_rd_count,
  input  logic [7:0]       fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      checksum
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
  ,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [7:0]       first_err_data
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam int               TMR_W    = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] BURST    = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(WAIT_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, recv_q, recv_d, err_q, err_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       exp_q, exp_d;
  logic [15:0]      sum_q, sum_d;
  logic             pass_q, pass_d, tmo_q, tmo_d, done_q, done_d;
  logic             rd_en_q, rd_en_d, vld_q;
  logic             capture, mismatch;
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
  logic             fe_vld_q, fe_vld_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [7:0]       fe_data_q, fe_data_d;
`endif

  // The read strobe is decided a cycle ahead; the live empty mask keeps it off during a stall.
  assign fifo_rd_en = rd_en_q & ~fifo_empty;
  assign capture    = vld_q && ((state_q == S_READ) || (state_q == S_DRAIN));
  assign mismatch   = capture && (fifo_rd_data != exp_q);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    timer_d  = timer_q;
    exp_d    = exp_q;
    err_d    = err_q;
    sum_d    = sum_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
    fe_vld_d  = fe_vld_q;
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    if (mismatch && !fe_vld_q) begin
      fe_vld_d  = 1'b1;
      fe_idx_d  = recv_q;
      fe_data_d = fifo_rd_data;
    end
`endif
    if (capture) begin
      sum_d  = sum_q + {8'h00, fifo_rd_data};
      exp_d  = exp_q + 8'd1;
      recv_d = recv_q + 1'b1;
      if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
    end
    if (fifo_rd_en) issued_d = issued_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issued_d = '0;
          recv_d   = '0;
          timer_d  = '0;
          exp_d    = expect_seed;
          err_d    = '0;
          sum_d    = '0;
          pass_d   = 1'b0;
          tmo_d    = 1'b0;
          state_d  = S_WAIT;
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
          fe_vld_d  = 1'b0;
          fe_idx_d  = '0;
          fe_data_d = '0;
`endif
        end
      end
      S_WAIT: begin
        if (fifo_rd_count >= BURST) begin
          timer_d = '0;
          state_d = S_READ;
        end else begin
          timer_d = timer_q + 1'b1;
          if ((WAIT_TIMEOUT != 0) && (timer_q == TMO_LAST)) begin
            tmo_d   = 1'b1;
            pass_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_READ: begin
        if (issued_d == BURST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the last byte lands so done trails the final strobe by two cycles.
        if (recv_d == BURST) begin
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_READ) && !fifo_empty && (issued_d < BURST);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      recv_q   <= '0;
      timer_q  <= '0;
      exp_q    <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      timer_q  <= timer_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      vld_q    <= fifo_rd_en;
    end
  end

`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fe_vld_q  <= 1'b0;
      fe_idx_q  <= '0;
      fe_data_q <= '0;
    end else begin
      fe_vld_q  <= fe_vld_d;
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
    end
  end

  assign first_err_vld  = fe_vld_q;
  assign first_err_idx  = fe_idx_q;
  assign first_err_data = fe_data_q;
`endif

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = tmo_q;
  assign err_cnt  = err_q;
  assign checksum = sum_q;

endmodule

// File: tb/tb_fifo_burst_checker.sv
// Directed bench for fifo_burst_checker with a behavioural non-FWFT FIFO on the read side.
module tb_fifo_burst_checker;
  localparam int BL = 256;
  localparam int CW = 9;
  localparam int TO = 1000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    expect_seed = 8'h00;
  logic          fifo_empty;
  logic [CW-1:0] fifo_rd_count;
  logic [7:0]    fifo_rd_data = 8'h00;
  logic          fifo_rd_en, busy, done, pass, timeout;
  logic [CW-1:0] err_cnt;
  logic [15:0]   checksum;
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
  logic          first_err_vld;
  logic [CW-1:0] first_err_idx;
  logic [7:0]    first_err_data;
`endif

  int total = 0;
  int bad   = 0;

  fifo_burst_checker #(.BURST_LEN(BL), .CNT_W(CW), .WAIT_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .expect_seed(expect_seed),
    .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .checksum(checksum)
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_idx(first_err_idx), .first_err_data(first_err_data)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: sole owner of the queue; refills are requested by toggling fill_tog.
  logic [7:0] q[$];
  int         qcount = 0;
  int         rd_total = 0;
  int         viol = 0;
  logic       force_empty = 1'b0;
  logic       fill_tog = 1'b0, fill_seen = 1'b0;
  int         fill_n = 0, fill_bad = -1;
  logic [7:0] fill_base = 8'h00, fill_badv = 8'h00;

  assign fifo_empty    = (qcount == 0) || force_empty;
  assign fifo_rd_count = qcount[CW-1:0];

  always @(posedge sys_clk) begin
    if (fill_tog != fill_seen) begin
      fill_seen <= fill_tog;
      q.delete();
      for (int i = 0; i < fill_n; i++)
        q.push_back((i == fill_bad) ? fill_badv : fill_base + 8'(i));
    end else if (fifo_rd_en) begin
      if (fifo_empty) viol <= viol + 1;
      else begin
        fifo_rd_data <= q.pop_front();
        rd_total     <= rd_total + 1;
      end
    end
    qcount <= q.size();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic fill(input int n, input logic [7:0] base, input int bidx, input logic [7:0] bval);
    @(negedge sys_clk);
    fill_n = n; fill_base = base; fill_bad = bidx; fill_badv = bval;
    fill_tog = ~fill_tog;
    @(negedge sys_clk);
    @(negedge sys_clk);
  endtask

  // n = posedges since the start edge; stimulus changes on negedges only.
  task automatic run(input logic [7:0] seed, input int stall_at, input int restart_at,
                     input int reset_at, output int first_rd, output int last_rd,
                     output int done_at, output int reads);
    int base, stall_end;
    bit stalled;
    base = rd_total; first_rd = -1; last_rd = -1; done_at = -1;
    stalled = 0; stall_end = -1;
    @(negedge sys_clk);
    expect_seed = seed; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge sys_clk);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = n;
        last_rd = n;
      end
      if (done) begin done_at = n; break; end
      if (stall_at >= 0 && !stalled && (rd_total - base) == stall_at) begin
        force_empty = 1'b1; stalled = 1; stall_end = n + 20;
      end else if (n == stall_end) force_empty = 1'b0;
      if (n == restart_at) begin start = 1'b1; expect_seed = 8'h55; end
      else start = 1'b0;
      if (reset_at >= 0 && (rd_total - base) == reset_at) begin sys_rst_n = 1'b0; break; end
    end
    start = 1'b0;
    force_empty = 1'b0;
    reads = rd_total - base;
  endtask

  initial begin
    int fr, lr, da, rd;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass_tmo", {pass, timeout}, 0);
    chk("rst_err_sum", {err_cnt, checksum}, 0);
    chk("rst_rden", fifo_rd_en, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // clean 0x00..0xFF burst
    fill(256, 8'h00, -1, 8'h00);
    run(8'h00, -1, -1, -1, fr, lr, da, rd);
    chk("a_first_rd", fr, 1);
    chk("a_last_rd", lr, 256);
    chk("a_done_lat", da - lr, 2);
    chk("a_reads", rd, 256);
    chk("a_pass", pass, 1);
    chk("a_err", err_cnt, 0);
    chk("a_sum", checksum, 16'h7F80);
    chk("a_tmo", timeout, 0);
    @(negedge sys_clk);
    chk("a_done_pulse", done, 0);
    chk("a_pass_held", pass, 1);
    chk("a_idle", busy, 0);

    // byte 17 corrupted
    fill(256, 8'h00, 17, 8'hAA);
    run(8'h00, -1, -1, -1, fr, lr, da, rd);
    chk("b_pass", pass, 0);
    chk("b_err", err_cnt, 1);
    chk("b_sum", checksum, 16'h8019);
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
    chk("b_fe_vld", first_err_vld, 1);
    chk("b_fe_idx", first_err_idx, 17);
    chk("b_fe_data", first_err_data, 8'hAA);
`endif

    // seed 0xF0, pattern wraps through 0xFF
    fill(256, 8'hF0, -1, 8'h00);
    run(8'hF0, -1, -1, -1, fr, lr, da, rd);
    chk("c_pass", pass, 1);
    chk("c_err", err_cnt, 0);
    chk("c_sum", checksum, 16'h7F80);
`ifdef FIFO_BURST_CHECKER_ERR_CAPTURE_EN
    chk("c_fe_clr", {first_err_vld, first_err_idx, first_err_data}, 0);
`endif

    // every byte wrong: seed 0x80 vs data 0x00..
    fill(256, 8'h00, -1, 8'h00);
    run(8'h80, -1, -1, -1, fr, lr, da, rd);
    chk("d_err", err_cnt, 256);
    chk("d_pass", pass, 0);

    // only 100 bytes: timeout
    fill(100, 8'h00, -1, 8'h00);
    run(8'h00, -1, -1, -1, fr, lr, da, rd);
    chk("e_done_at", da, TO);
    chk("e_reads", rd, 0);
    chk("e_tmo", timeout, 1);
    chk("e_pass", pass, 0);
    chk("e_busy", busy, 0);
    chk("e_left", qcount, 100);
    @(negedge sys_clk);
    chk("e_tmo_held", timeout, 1);

    // 20-cycle underflow stall after 100 reads
    fill(256, 8'h00, -1, 8'h00);
    run(8'h00, 100, -1, -1, fr, lr, da, rd);
    chk("f_reads", rd, 256);
    chk("f_no_rd_when_empty", viol, 0);
    chk("f_pass", pass, 1);
    chk("f_tmo_clr", timeout, 0);

    // second start mid-run is ignored
    fill(256, 8'h00, -1, 8'h00);
    run(8'h00, -1, 30, -1, fr, lr, da, rd);
    chk("g_done_at", da, 258);
    chk("g_pass", pass, 1);
    chk("g_err", err_cnt, 0);

    // reset after 50 reads
    fill(256, 8'h00, -1, 8'h00);
    run(8'h00, -1, -1, 50, fr, lr, da, rd);
    #1;
    chk("h_rst_busy", busy, 0);
    chk("h_rst_outs", {fifo_rd_en, done, pass, timeout, err_cnt, checksum}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("h_post_busy", busy, 0);
    chk("h_post_sum", checksum, 0);
    chk("h_left", qcount, 206);

    // recovers after reset
    fill(256, 8'h00, -1, 8'h00);
    run(8'h00, -1, -1, -1, fr, lr, da, rd);
    chk("i_pass", pass, 1);
    chk("i_reads", rd, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
